quad_decoder_pos_speed: RTL and testbench

Parametrised next-generation quadrature decoder for motor-encoder inputs. Synchronises and glitch-filters phases A/B, decodes x4 steps with direction, maintains a wrapping signed position count, and measures speed as signed steps per fixed window. Illegal transitions are flagged. It sits between the encoder pins and the AXI register block of the encoder IP.

---
 rtl/quad_decoder_pos_speed.sv | 154 +++++++++++++++
 tb/tb_quad_decoder_pos_speed.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder_pos_speed.sv
// Quadrature encoder front end: synchronise and filter phases A/B, decode x4 steps,
// keep a wrapping position count and report saturated steps per fixed speed window.
module quad_decoder_pos_speed #(
  parameter int POS_W       = 32,
  parameter int SPD_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int WINDOW      = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ph_a,
  input  logic                    ph_b,
  input  logic                    pos_clr,
  input  logic                    err_clr,
  output logic [POS_W-1:0]        position,
  output logic                    dir,
  output logic                    step_pulse,
  output logic signed [SPD_W-1:0] speed,
  output logic                    speed_valid,
  output logic                    err
);

  localparam int FCW = $clog2(FILT_LEN + 1);
  localparam int WCW = $clog2(WINDOW);
  localparam logic signed [SPD_W:0] SPD_MAX = (SPD_W + 1)'(2 ** (SPD_W - 1) - 1);
  localparam logic signed [SPD_W:0] SPD_MIN = -SPD_MAX;

  logic [SYNC_STAGES-1:0] syncA;
  logic [SYNC_STAGES-1:0] syncB;
  logic [1:0]             syncAB;
  logic [1:0]             filtAB;
  logic [FCW-1:0]         filtCnt [2];
  logic [1:0]             prevAB;
  logic                   stepFwd;
  logic                   stepRev;
  logic                   illegal;
  logic [POS_W-1:0]       posStep;
  logic signed [SPD_W-1:0] acc;
  logic signed [SPD_W-1:0] accNext;
  logic [WCW-1:0]         winCnt;

  // Symmetric saturation keeps the window sum inside +/-(2^(SPD_W-1)-1).
  function automatic logic signed [SPD_W-1:0] satAdd(input logic signed [SPD_W-1:0] a,
                                                     input logic up, input logic down);
    logic signed [SPD_W:0] sum;
    sum = {a[SPD_W-1], a};
    if (up) begin
      sum = sum + (SPD_W + 1)'(1);
    end else if (down) begin
      sum = sum - (SPD_W + 1)'(1);
    end else begin
      sum = sum;
    end
    if (sum > SPD_MAX) begin
      return SPD_MAX[SPD_W-1:0];
    end else if (sum < SPD_MIN) begin
      return SPD_MIN[SPD_W-1:0];
    end else begin
      return sum[SPD_W-1:0];
    end
  endfunction

  // Plain flop chains for both phases; no logic between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncA <= '0;
      syncB <= '0;
    end else begin
      syncA <= {syncA[SYNC_STAGES-2:0], ph_a};
      syncB <= {syncB[SYNC_STAGES-2:0], ph_b};
    end
  end

  assign syncAB = {syncA[SYNC_STAGES-1], syncB[SYNC_STAGES-1]};

  // Accept a new phase level only after FILT_LEN consecutive differing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filtAB <= 2'b00;
      for (int i = 0; i < 2; i++) filtCnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (syncAB[i] == filtAB[i]) begin
          filtCnt[i] <= '0;
        end else if (filtCnt[i] == FCW'(FILT_LEN - 1)) begin
          filtAB[i]  <= syncAB[i];
          filtCnt[i] <= '0;
        end else begin
          filtCnt[i] <= filtCnt[i] + FCW'(1);
        end
      end
    end
  end

  // Forward Gray order {a,b}: 00 -> 10 -> 11 -> 01 -> 00.
  always_comb begin
    stepFwd = 1'b0;
    stepRev = 1'b0;
    illegal = 1'b0;
    case ({prevAB, filtAB})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: stepFwd = 1'b1;
      4'b1000, 4'b1110, 4'b0111, 4'b0001: stepRev = 1'b1;
      4'b0011, 4'b1100, 4'b1001, 4'b0110: illegal = 1'b1;
      default:                            illegal = 1'b0;
    endcase
  end

  assign posStep = {{(POS_W - 1){stepRev}}, stepFwd | stepRev};
  assign accNext = satAdd(acc, stepFwd, stepRev);

  // Position, direction, step strobe and sticky error; set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prevAB     <= 2'b00;
      position   <= '0;
      dir        <= 1'b0;
      step_pulse <= 1'b0;
      err        <= 1'b0;
    end else begin
      prevAB     <= filtAB;
      step_pulse <= stepFwd | stepRev;
      position   <= pos_clr ? '0 : position + posStep;
      err        <= illegal | (err & ~err_clr);
      if (stepFwd) begin
        dir <= 1'b1;
      end else if (stepRev) begin
        dir <= 1'b0;
      end else begin
        dir <= dir;
      end
    end
  end

  // Free-running speed gate; the final cycle's step is folded into the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winCnt      <= '0;
      acc         <= '0;
      speed       <= '0;
      speed_valid <= 1'b0;
    end else if (winCnt == WCW'(WINDOW - 1)) begin
      winCnt      <= '0;
      acc         <= '0;
      speed       <= accNext;
      speed_valid <= 1'b1;
    end else begin
      winCnt      <= winCnt + WCW'(1);
      acc         <= accNext;
      speed_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_decoder_pos_speed.sv
// Directed bench: two decoder instances (wide and narrow widths) share one pin stimulus.
module tb_quad_decoder_pos_speed;
  localparam int SS  = 2;
  localparam int FL  = 4;
  localparam int WIN = 100;
  localparam int LAT = SS + FL + 1;

  logic clk = 1'b0, rst_n = 1'b0, ph_a = 1'b0, ph_b = 1'b0, pos_clr = 1'b0, err_clr = 1'b0;
  logic [31:0]        pos16;
  logic [7:0]         pos8;
  logic signed [15:0] spd16;
  logic signed [3:0]  spd8;
  logic dir16, sp16, sv16, err16, dir8, sp8, sv8, err8;

  int passed = 0, total = 0, pulseCnt = 0, cyc = 0, gIdx = 0, p0 = 0;

  quad_decoder_pos_speed #(.POS_W(32), .SPD_W(16), .SYNC_STAGES(SS), .FILT_LEN(FL), .WINDOW(WIN)) dut16 (
    .clk(clk), .rst_n(rst_n), .ph_a(ph_a), .ph_b(ph_b), .pos_clr(pos_clr), .err_clr(err_clr),
    .position(pos16), .dir(dir16), .step_pulse(sp16), .speed(spd16), .speed_valid(sv16), .err(err16));

  quad_decoder_pos_speed #(.POS_W(8), .SPD_W(4), .SYNC_STAGES(SS), .FILT_LEN(FL), .WINDOW(WIN)) dut8 (
    .clk(clk), .rst_n(rst_n), .ph_a(ph_a), .ph_b(ph_b), .pos_clr(pos_clr), .err_clr(err_clr),
    .position(pos8), .dir(dir8), .step_pulse(sp8), .speed(spd8), .speed_valid(sv8), .err(err8));

  always #5 clk = ~clk;

  always @(negedge clk) if (sp16) pulseCnt++;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [1:0] gray(input int i);
    case (i & 3)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic drive(input bit fwd);
    gIdx = fwd ? gIdx + 1 : gIdx - 1;
    {ph_a, ph_b} = gray(gIdx);
  endtask

  task automatic stepFast(input bit fwd, input int gap);
    @(negedge clk);
    drive(fwd);
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic stepLat(input bit fwd);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    @(negedge clk);
    drive(fwd);
    while (!seen && n < 30) begin
      @(posedge clk);
      #1;
      n++;
      seen = (sp16 === 1'b1);
    end
    chk("step_latency", n, LAT);
    @(posedge clk);
    #1;
    chk("step_pulse_width", sp16, 0);
    repeat (12) @(negedge clk);
  endtask

  task automatic waitValid();
    bit found;
    found = 1'b0;
    for (int n = 0; n < 250 && !found; n++) begin
      @(posedge clk);
      #1;
      found = (sv16 === 1'b1);
    end
    chk("speed_valid_seen", found, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_position", pos16, 0);
    chk("rst_dir", dir16, 0);
    chk("rst_step_pulse", sp16, 0);
    chk("rst_speed", spd16, 0);
    chk("rst_speed_valid", sv16, 0);
    chk("rst_err", err16, 0);
    @(negedge clk) rst_n = 1'b1;

    p0 = pulseCnt;
    for (int i = 0; i < 8; i++) stepLat(1'b1);
    chk("fwd8_pos16", pos16, 8);
    chk("fwd8_pos8", pos8, 8);
    chk("fwd8_dir", dir16, 1);
    chk("fwd8_err", err16, 0);
    chk("fwd8_pulses", pulseCnt - p0, 8);

    for (int i = 0; i < 3; i++) stepLat(1'b0);
    chk("rev3_pos", pos16, 5);
    chk("rev3_dir", dir16, 0);

    p0 = pulseCnt;
    @(negedge clk) ph_a = ~ph_a;
    repeat (3) @(negedge clk);
    ph_a = ~ph_a;
    repeat (20) @(negedge clk);
    chk("glitch_pos", pos16, 5);
    chk("glitch_pulses", pulseCnt - p0, 0);

    // Both phases flip at once: 10 -> 01.
    @(negedge clk);
    {ph_a, ph_b} = 2'b01;
    gIdx = 3;
    repeat (15) @(negedge clk);
    chk("illegal_err16", err16, 1);
    chk("illegal_err8", err8, 1);
    chk("illegal_pos", pos16, 5);
    chk("illegal_dir", dir16, 0);
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    chk("err_clr", err16, 0);

    @(negedge clk);
    {ph_a, ph_b} = 2'b10;
    gIdx = 1;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk) err_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("err_set_wins", err16, 1);
    @(negedge clk) err_clr = 1'b0;
    @(posedge clk);
    #1;
    chk("err_sticky", err16, 1);

    @(negedge clk) pos_clr = 1'b1;
    @(negedge clk) pos_clr = 1'b0;
    chk("pos_clr", pos16, 0);
    for (int i = 0; i < 127; i++) stepFast(1'b1, 8);
    repeat (10) @(negedge clk);
    chk("pre_wrap_pos8", pos8, 127);
    stepFast(1'b1, 8);
    repeat (10) @(negedge clk);
    chk("wrap_pos8", pos8, 128);
    chk("wrap_pos16", pos16, 128);

    @(negedge clk);
    drive(1'b1);
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk) pos_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_step_pulse", sp16, 1);
    chk("clr_wins_pos16", pos16, 0);
    chk("clr_wins_pos8", pos8, 0);
    chk("clr_step_dir", dir16, 1);
    @(negedge clk) pos_clr = 1'b0;
    stepFast(1'b0, 8);
    repeat (10) @(negedge clk);
    chk("under_pos16", pos16, 64'hFFFF_FFFF);
    chk("under_pos8", pos8, 255);

    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("rst2_err", err16, 0);
    chk("rst2_pos", pos16, 0);
    ph_a = 1'b0;
    ph_b = 1'b0;
    gIdx = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) stepFast(1'b1, 3);
    waitValid();
    chk("win1_cycle", cyc, 100);
    chk("win1_speed16", $signed(spd16), 25);
    chk("win1_speed4", $signed(spd8), 7);
    chk("win1_valid4", sv8, 1);
    @(posedge clk);
    #1;
    chk("valid_drop", sv16, 0);
    chk("speed_hold", $signed(spd16), 25);

    for (int i = 0; i < 10; i++) stepFast(1'b0, 3);
    waitValid();
    chk("win2_cycle", cyc, 200);
    chk("win2_speed16", $signed(spd16), -10);
    chk("win2_speed4", $signed(spd8), -7);

    for (int i = 0; i < 12; i++) stepFast(1'b1, 3);
    waitValid();
    chk("win3_cycle", cyc, 300);
    chk("win3_speed16", $signed(spd16), 12);
    chk("win3_speed4", $signed(spd8), 7);

    for (int i = 0; i < 5; i++) stepFast(1'b1, 3);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_pos", pos16, 0);
    chk("midrst_dir", dir16, 0);
    chk("midrst_speed16", $signed(spd16), 0);
    chk("midrst_speed4", $signed(spd8), 0);
    chk("midrst_step_pulse", sp16, 0);
    chk("midrst_valid", sv16, 0);
    chk("midrst_pos8", pos8, 0);
    ph_a = 1'b0;
    ph_b = 1'b0;
    gIdx = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitValid();
    chk("post_rst_cycle", cyc, 100);
    chk("post_rst_speed", $signed(spd16), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
